// File: rtl/in_register.sv
// Dual-operand parallel-in/serial-out register feeding a bit-serial adder.
// Latency: bit k valid k+1 cycles after the accepting edge; done pulses WIDTH+1 cycles after it.
// Backpressure: hold freezes the whole shift sequence in place; start is ignored while busy.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           load request, accepted only when idle
//   hold            stall request, freezes shifting while busy
//   a, b            operands, sampled on the accepting edge only
//   a_inbit/b_inbit current serial bit pair (0 when bit_valid is low)
//   bit_valid       serial pair carries operand bits
//   first_bit       pair is bit 0 (adder clears its carry)
//   last_bit        pair is bit WIDTH-1 (adder closes its carry chain)
//   bit_index       index of the current pair, 0 when idle
//   busy            transfer in progress
//   done            one-cycle pulse in the cycle after the last pair

module in_register #(
    parameter  int WIDTH = 4,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             hold,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             a_inbit,
    output logic             b_inbit,
    output logic             bit_valid,
    output logic             first_bit,
    output logic             last_bit,
    output logic [CW-1:0]    bit_index,
    output logic             busy,
    output logic             done
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("in_register: WIDTH must be in 1..32");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // cnt holds the index of the next pair to present; reaching WIDTH means
    // every pair has been shown and the next unheld edge closes the transfer.
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_END  = CW'(WIDTH);

    state_t           state_q,     state_d;
    logic [WIDTH-1:0] a_sh_q,      a_sh_d;
    logic [WIDTH-1:0] b_sh_q,      b_sh_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic             a_inbit_q,   a_inbit_d;
    logic             b_inbit_q,   b_inbit_d;
    logic             bit_valid_q, bit_valid_d;
    logic             first_bit_q, first_bit_d;
    logic             last_bit_q,  last_bit_d;
    logic [CW-1:0]    bit_index_q, bit_index_d;
    logic             done_q,      done_d;

    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        cnt_d       = cnt_q;
        a_inbit_d   = a_inbit_q;
        b_inbit_d   = b_inbit_q;
        bit_valid_d = bit_valid_q;
        first_bit_d = first_bit_q;
        last_bit_d  = last_bit_q;
        bit_index_d = bit_index_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                // Serial outputs are already zero here: they are cleared on
                // the closing edge and by reset, so only start matters.
                if (start) begin
                    a_inbit_d   = a[0];
                    b_inbit_d   = b[0];
                    a_sh_d      = a >> 1;
                    b_sh_d      = b >> 1;
                    bit_valid_d = 1'b1;
                    first_bit_d = 1'b1;
                    last_bit_d  = (WIDTH == 1);
                    bit_index_d = '0;
                    cnt_d       = CW'(1);
                    state_d     = SHIFT;
                end
            end

            SHIFT: begin
                // hold keeps every register, including the closing edge, so a
                // stall anywhere simply stretches the sequence by one cycle.
                if (!hold) begin
                    if (cnt_q != CNT_END) begin
                        a_inbit_d   = a_sh_q[0];
                        b_inbit_d   = b_sh_q[0];
                        a_sh_d      = a_sh_q >> 1;
                        b_sh_d      = b_sh_q >> 1;
                        bit_index_d = cnt_q;
                        first_bit_d = 1'b0;
                        last_bit_d  = (cnt_q == LAST_IDX);
                        cnt_d       = cnt_q + CW'(1);
                    end else begin
                        a_inbit_d   = 1'b0;
                        b_inbit_d   = 1'b0;
                        bit_valid_d = 1'b0;
                        first_bit_d = 1'b0;
                        last_bit_d  = 1'b0;
                        bit_index_d = '0;
                        cnt_d       = '0;
                        done_d      = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            cnt_q       <= '0;
            a_inbit_q   <= 1'b0;
            b_inbit_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            first_bit_q <= 1'b0;
            last_bit_q  <= 1'b0;
            bit_index_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            cnt_q       <= cnt_d;
            a_inbit_q   <= a_inbit_d;
            b_inbit_q   <= b_inbit_d;
            bit_valid_q <= bit_valid_d;
            first_bit_q <= first_bit_d;
            last_bit_q  <= last_bit_d;
            bit_index_q <= bit_index_d;
            done_q      <= done_d;
        end
    end

    assign a_inbit   = a_inbit_q;
    assign b_inbit   = b_inbit_q;
    assign bit_valid = bit_valid_q;
    assign first_bit = first_bit_q;
    assign last_bit  = last_bit_q;
    assign bit_index = bit_index_q;
    assign busy      = (state_q == SHIFT);
    assign done      = done_q;

endmodule

// File: tb/tb_in_register.sv
// Self-checking bench for in_register at WIDTH=4 (cycle-exact trace), WIDTH=1 and WIDTH=8 (serial sum).
// Latency: expected traces are queued before the accepting edge and popped one per cycle.
// Backpressure: hold and ignored-start cases are driven on the WIDTH=4 instance.

module tb_in_register;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // WIDTH=4 instance
    logic       start4, hold4;
    logic [3:0] a4, b4;
    logic       ai4, bi4, v4, f4, l4, busy4, done4;
    logic [2:0] idx4;

    // WIDTH=1 instance
    logic       start1, hold1;
    logic [0:0] a1, b1;
    logic       ai1, bi1, v1, f1, l1, busy1, done1;
    logic [0:0] idx1;

    // WIDTH=8 instance
    logic       start8, hold8;
    logic [7:0] a8, b8;
    logic       ai8, bi8, v8, f8, l8, busy8, done8;
    logic [3:0] idx8;

    in_register #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .hold(hold4), .a(a4), .b(b4),
        .a_inbit(ai4), .b_inbit(bi4), .bit_valid(v4), .first_bit(f4), .last_bit(l4),
        .bit_index(idx4), .busy(busy4), .done(done4)
    );

    in_register #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .hold(hold1), .a(a1), .b(b1),
        .a_inbit(ai1), .b_inbit(bi1), .bit_valid(v1), .first_bit(f1), .last_bit(l1),
        .bit_index(idx1), .busy(busy1), .done(done1)
    );

    in_register #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .hold(hold8), .a(a8), .b(b8),
        .a_inbit(ai8), .b_inbit(bi8), .bit_valid(v8), .first_bit(f8), .last_bit(l8),
        .bit_index(idx8), .busy(busy8), .done(done8)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", tag, $time, obs, exp);
        end
    endtask

    // Per-cycle record of the WIDTH=4 outputs: {a,b,valid,first,last,idx[2:0],busy,done}
    typedef logic [9:0] rec_t;
    localparam rec_t IDLE_REC = '0;

    function automatic rec_t mk(input logic ai, input logic bi, input logic v,
                                input logic f, input logic l, input logic [2:0] idx,
                                input logic bsy, input logic dn);
        return {ai, bi, v, f, l, idx, bsy, dn};
    endfunction

    rec_t obs4;
    assign obs4 = {ai4, bi4, v4, f4, l4, idx4, busy4, done4};

    logic [7:0] obs1;
    assign obs1 = {ai1, bi1, v1, f1, l1, idx1, busy1, done1};
    logic [10:0] obs8;
    assign obs8 = {ai8, bi8, v8, f8, l8, idx8, busy8, done8};

    rec_t       exp4_q[$];
    bit         chk4_en = 1'b0;
    logic [8:0] exp8_q[$];
    logic [1:0] exp1_q[$];

    // Expected WIDTH=4 trace, starting at the cycle before the accepting edge.
    // Bit hold_bit is shown for 1+hold_len cycles; done follows the last bit.
    task automatic push_trace(input logic [3:0] a, input logic [3:0] b,
                              input int hold_bit, input int hold_len);
        if (exp4_q.size() == 0) exp4_q.push_back(IDLE_REC);
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < ((k == hold_bit) ? 1 + hold_len : 1); r++)
                exp4_q.push_back(mk(a[k], b[k], 1'b1, k == 0, k == 3, 3'(k), 1'b1, 1'b0));
        end
        exp4_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1));
    endtask

    // Called at posedge+1; returns at posedge+1 inside the done cycle.
    task automatic xfer4(input logic [3:0] a, input logic [3:0] b,
                         input int hold_bit, input int hold_len, input int poke_bit);
        int cur;
        int held;
        push_trace(a, b, hold_bit, hold_len);
        a4 = a; b4 = b; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0; hold4 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom);
        cur = 0; held = 0;
        while (cur < 4) begin
            hold4  = (cur == hold_bit && held < hold_len);
            start4 = (cur == poke_bit && !hold4);
            if (start4) begin a4 = 4'hF; b4 = 4'hF; end
            @(posedge clk); #1;
            if (hold4) held++; else cur++;
        end
        hold4 = 1'b0; start4 = 1'b0;
    endtask

    // WIDTH=4 trace monitor: an empty queue means the block must be idle.
    initial forever begin
        rec_t e;
        @(negedge clk);
        if (chk4_en) begin
            e = (exp4_q.size() != 0) ? exp4_q.pop_front() : IDLE_REC;
            chk($sformatf("w4_trace(exp=%b)", e), 32'(obs4), 32'(e));
        end
    end

    // Serial-adder reconstruction for WIDTH=8 and WIDTH=1.
    logic [8:0] sum8;
    logic       c8;
    initial forever begin
        logic c;
        @(negedge clk);
        if (v8) begin
            c = f8 ? 1'b0 : c8;
            sum8[idx8] = ai8 ^ bi8 ^ c;
            c8 = (ai8 & bi8) | (ai8 & c) | (bi8 & c);
            if (l8) sum8[8] = c8;
        end
        if (done8) begin
            if (exp8_q.size() != 0) chk("w8_sum", 32'(sum8), 32'(exp8_q.pop_front()));
            else chk("w8_spurious_done", 32'(done8), 32'd0);
        end
    end

    logic [1:0] sum1;
    logic       c1;
    initial forever begin
        logic c;
        @(negedge clk);
        if (v1) begin
            c = f1 ? 1'b0 : c1;
            sum1[idx1] = ai1 ^ bi1 ^ c;
            c1 = (ai1 & bi1) | (ai1 & c) | (bi1 & c);
            if (l1) sum1[1] = c1;
            chk("w1_first_last", 32'({f1, l1}), 32'd3);
        end
        if (done1) begin
            if (exp1_q.size() != 0) chk("w1_sum", 32'(sum1), 32'(exp1_q.pop_front()));
            else chk("w1_spurious_done", 32'(done1), 32'd0);
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        start4 = 1'b0; hold4 = 1'b0; a4 = '0; b4 = '0;
        start1 = 1'b0; hold1 = 1'b0; a1 = '0; b1 = '0;
        start8 = 1'b0; hold8 = 1'b0; a8 = '0; b8 = '0;
        sum8 = '0; c8 = 1'b0; sum1 = '0; c1 = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("rst_w4", 32'(obs4), 32'd0);
        chk("rst_w1", 32'(obs1), 32'd0);
        chk("rst_w8", 32'(obs8), 32'd0);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk4_en = 1'b1;
        hold4 = 1'b1;               // hold must be ignored while idle
        repeat (2) @(posedge clk);
        #1;

        // Basic transfer (hold still high on the accepting edge)
        xfer4(4'b1011, 4'b0110, -1, 0, -1);
        repeat (2) @(posedge clk);
        #1;

        // Hold two cycles during bit 1
        xfer4(4'b1011, 4'b0110, 1, 2, -1);
        repeat (2) @(posedge clk);
        #1;

        // start with a=F during bit 2 must be ignored, no second transfer
        xfer4(4'b1011, 4'b0110, -1, 0, 2);
        repeat (3) @(posedge clk);
        #1;

        // Back-to-back: second start in the done cycle
        xfer4(4'h5, 4'hA, -1, 0, -1);
        xfer4(4'h3, 4'hC, -1, 0, -1);
        repeat (2) @(posedge clk);
        #1;
        chk("w4_queue_drained", 32'(exp4_q.size()), 32'd0);

        // Reset mid-transfer, asserted between clock edges during bit 2
        chk4_en = 1'b0;
        exp4_q.delete();
        a4 = 4'hD; b4 = 4'h2; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_idx", 32'(idx4), 32'd2);
        chk("mid_busy", 32'(busy4), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_w4", 32'(obs4), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_done_after_rst", 32'({busy4, done4}), 32'd0);
        end
        @(posedge clk); #1;
        chk4_en = 1'b1;
        xfer4(4'hD, 4'h2, -1, 0, -1);
        repeat (2) @(posedge clk);
        #1;
        chk4_en = 1'b0;

        // Random operands on WIDTH=8 and WIDTH=1, some back-to-back
        fork
            begin
                for (int t = 0; t < 8; t++) begin
                    logic [7:0] x;
                    logic [7:0] y;
                    x = 8'($urandom); y = 8'($urandom);
                    a8 = x; b8 = y; start8 = 1'b1;
                    exp8_q.push_back({1'b0, x} + {1'b0, y});
                    @(posedge clk); #1;
                    start8 = 1'b0;
                    a8 = 8'($urandom); b8 = 8'($urandom);
                    repeat (8) @(posedge clk);
                    #1;
                    if (t % 2 == 1) begin
                        repeat (2) @(posedge clk);
                        #1;
                    end
                end
            end
            begin
                for (int t = 0; t < 10; t++) begin
                    logic [0:0] x;
                    logic [0:0] y;
                    x = 1'($urandom); y = 1'($urandom);
                    if (t < 4) begin x = 1'(t); y = 1'(t >> 1); end
                    a1 = x; b1 = y; start1 = 1'b1;
                    exp1_q.push_back({1'b0, x} + {1'b0, y});
                    @(posedge clk); #1;
                    start1 = 1'b0;
                    @(posedge clk); #1;
                    if (t % 3 == 2) begin
                        @(posedge clk); #1;
                    end
                end
            end
        join

        repeat (4) @(posedge clk);
        #1;
        chk("w8_pending", 32'(exp8_q.size()), 32'd0);
        chk("w1_pending", 32'(exp1_q.size()), 32'd0);
        chk("w8_idle", 32'(obs8), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
